// File: rtl/shared_reg_arbiter_pkg.sv
// Shared definitions for the round-robin shared-register arbiter: FSM states and default sizing.
package shared_reg_arbiter_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_N     = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Round-robin pick: first set req bit searching upward from owner+1 with wrap-around.
// Purely combinational, zero latency; returns all zeros when no request is pending.
module rr_pick
   import shared_reg_arbiter_pkg::*;
#(
   parameter int N = DEF_N
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] owner,
   output logic [N-1:0]         pick
);

   localparam int IW = $clog2(N);

   logic [IW-1:0] idx;
   logic          found;

   // N is a power of two, so the index addition wraps modulo N on its own
   always_comb begin
      pick  = '0;
      found = 1'b0;
      idx   = owner;
      for (int k = 1; k <= N; k++) begin
         idx = owner + IW'(k);
         if (!found && req[idx]) begin
            pick[idx] = 1'b1;
            found     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Arbitrates N writers onto one shared register: grant 1 cycle after request, write+ack 1 cycle later.
// One write per 3 cycles; requesters wait with req held high, dropping req during GRANT abandons.
module shared_reg_arbiter
   import shared_reg_arbiter_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int N     = DEF_N
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         req,
   input  logic [N*WIDTH-1:0]   wdata,
   output logic [N-1:0]         gnt,
   output logic [N-1:0]         ack,
   output logic [WIDTH-1:0]     q,
   output logic                 busy,
   output logic [$clog2(N)-1:0] owner
);

   localparam int IW = $clog2(N);

   state_t           state;
   state_t           state_nxt;
   logic [N-1:0]     pick;
   logic [N-1:0]     gnt_nxt;
   logic [N-1:0]     ack_nxt;
   logic [WIDTH-1:0] q_nxt;
   logic [WIDTH-1:0] win_dat;
   logic [IW-1:0]    owner_nxt;
   logic [IW-1:0]    win_idx;
   logic             win_req;

   rr_pick #(.N(N)) u_rr_pick (
      .req   (req),
      .owner (owner),
      .pick  (pick)
   );

   // Decode the one-hot grant into the winner's index and its live data slice
   always_comb begin
      win_idx = '0;
      win_dat = '0;
      for (int i = 0; i < N; i++) begin
         if (gnt[i]) begin
            win_idx = IW'(i);
            win_dat = wdata[i*WIDTH +: WIDTH];
         end
      end
   end

   assign win_req = |(req & gnt);

   always_comb begin
      state_nxt = state;
      gnt_nxt   = '0;
      ack_nxt   = '0;
      q_nxt     = q;
      owner_nxt = owner;
      case (state)
         IDLE: begin
            if (|req) begin
               gnt_nxt   = pick;
               state_nxt = GRANT;
            end
         end
         GRANT: begin
            if (win_req) begin
               q_nxt     = win_dat;
               ack_nxt   = gnt;
               owner_nxt = win_idx;
               state_nxt = DONE;
            end else begin
               state_nxt = IDLE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         gnt   <= '0;
         ack   <= '0;
         q     <= '0;
         busy  <= 1'b0;
         owner <= IW'(N - 1);
      end else begin
         state <= state_nxt;
         gnt   <= gnt_nxt;
         ack   <= ack_nxt;
         q     <= q_nxt;
         busy  <= (state_nxt != IDLE);
         owner <= owner_nxt;
      end
   end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Bench for shared_reg_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_shared_reg_arbiter;

   localparam int W = 8;
   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req;
   logic [N*W-1:0] wdata;
   logic [N-1:0]   gnt;
   logic [N-1:0]   ack;
   logic [W-1:0]   q;
   logic           busy;
   logic [1:0]     owner;

   shared_reg_arbiter #(.WIDTH(W), .N(N)) dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .wdata (wdata),
      .gnt   (gnt),
      .ack   (ack),
      .q     (q),
      .busy  (busy),
      .owner (owner)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Reference model: phase 0 waiting, 1 granted to m_win, 2 write just completed
   int           ph      = 0;
   int           m_win   = 0;
   int           m_owner = N - 1;
   logic [N-1:0] m_gnt   = '0;
   logic [N-1:0] m_ack   = '0;
   logic [W-1:0] m_q     = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
      end
   endtask

   function automatic int rr_next(input logic [N-1:0] r, input int own);
      for (int k = 1; k <= N; k++)
         if (r[(own + k) % N]) return (own + k) % N;
      return -1;
   endfunction

   task automatic model_edge();
      if (rst) begin
         ph = 0; m_gnt = '0; m_ack = '0; m_q = '0; m_owner = N - 1;
      end else begin
         m_ack = '0;
         case (ph)
            0: if (req != 0) begin
                  m_win = rr_next(req, m_owner);
                  m_gnt = '0;
                  m_gnt[m_win] = 1'b1;
                  ph = 1;
               end
            1: begin
                  m_gnt = '0;
                  if (req[m_win]) begin
                     m_q = wdata[m_win*W +: W];
                     m_ack[m_win] = 1'b1;
                     m_owner = m_win;
                     ph = 2;
                  end else begin
                     ph = 0;
                  end
               end
            default: ph = 0;
         endcase
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      cyc++;
      #1;
      check("gnt",   32'(gnt),   32'(m_gnt));
      check("ack",   32'(ack),   32'(m_ack));
      check("q",     32'(q),     32'(m_q));
      check("busy",  32'(busy),  32'(ph != 0));
      check("owner", 32'(owner), 32'(m_owner));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = '0;
      step();
      rst = 1'b0;
   endtask

   int ack_idx[$];
   int ack_cyc[$];

   initial begin
      rst   = 1'b1;
      req   = '0;
      wdata = '0;

      // Scenario 1: single request, fixed latency
      do_reset();
      check("rst_gnt",   32'(gnt),   32'h0);
      check("rst_ack",   32'(ack),   32'h0);
      check("rst_q",     32'(q),     32'h0);
      check("rst_busy",  32'(busy),  32'h0);
      check("rst_owner", 32'(owner), 32'd3);
      req = 4'b0010;
      wdata[1*W +: W] = 8'hA5;
      step();
      check("s1_gnt", 32'(gnt), 32'b0010);
      check("s1_busy", 32'(busy), 32'h1);
      step();
      check("s1_q",   32'(q),   32'hA5);
      check("s1_ack", 32'(ack), 32'b0010);
      req = '0;
      step();
      check("s1_owner", 32'(owner), 32'd1);
      check("s1_idle",  32'(busy),  32'h0);

      // Scenario 2: all requesters held, rotation and 3-cycle spacing
      do_reset();
      wdata = 32'h44332211;
      req   = 4'b1111;
      for (int s = 0; s < 14; s++) begin
         step();
         for (int i = 0; i < N; i++)
            if (ack[i]) begin
               ack_idx.push_back(i);
               ack_cyc.push_back(cyc);
            end
      end
      check("s2_nacks", 32'(ack_idx.size()), 32'd5);
      for (int a = 0; a < 5 && a < ack_idx.size(); a++) begin
         check("s2_order", 32'(ack_idx[a]), 32'(a % N));
         if (a > 0) check("s2_gap", 32'(ack_cyc[a] - ack_cyc[a-1]), 32'd3);
      end

      // Scenario 3: wrap-around from owner 3
      do_reset();
      wdata = 32'hD0C0B0A0;
      req   = 4'b1001;
      step();
      check("s3_first", 32'(gnt), 32'b0001);
      step();
      check("s3_q0", 32'(q), 32'hA0);
      req = 4'b1000;
      step();
      step();
      check("s3_second", 32'(gnt), 32'b1000);
      step();
      check("s3_q3", 32'(q), 32'hD0);
      req = '0;
      step();

      // Scenario 4: requester 2 abandons during GRANT
      req = 4'b0100;
      wdata[2*W +: W] = 8'h77;
      step();
      check("s4_gnt", 32'(gnt), 32'b0100);
      req = '0;
      step();
      check("s4_ack",   32'(ack),   32'h0);
      check("s4_q",     32'(q),     32'hD0);
      check("s4_busy",  32'(busy),  32'h0);
      check("s4_owner", 32'(owner), 32'd3);

      // Scenario 5: reset lands in GRANT
      do_reset();
      req = 4'b0001;
      wdata[0 +: W] = 8'h3C;
      step();
      check("s5_gnt", 32'(gnt), 32'b0001);
      rst = 1'b1;
      step();
      rst = 1'b0;
      req = '0;
      check("s5_q",     32'(q),     32'h0);
      check("s5_gnt0",  32'(gnt),   32'h0);
      check("s5_owner", 32'(owner), 32'd3);
      for (int s = 0; s < 3; s++) begin
         step();
         check("s5_noack", 32'(ack), 32'h0);
      end

      // Scenario 6: data changes mid-GRANT
      req = 4'b0001;
      wdata[0 +: W] = 8'h11;
      step();
      wdata[0 +: W] = 8'h22;
      step();
      check("s6_q", 32'(q), 32'h22);
      req = '0;
      step();

      // Random traffic: requesters hold until ack, sometimes abandon, rare resets
      for (int s = 0; s < 400; s++) begin
         rst   = ($urandom_range(0, 59) == 0);
         wdata = $urandom;
         for (int i = 0; i < N; i++) begin
            if (ack[i]) req[i] = 1'b0;
            else if (!req[i]) req[i] = ($urandom_range(0, 2) == 0);
            else if ($urandom_range(0, 19) == 0) req[i] = 1'b0;
         end
         step();
         check("onehot_gnt", 32'($countones(gnt) <= 1), 32'h1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
